// File: rtl/alu_seq_pkg.sv
// Opcode values and FSM state encoding shared by the ALU operation sequencer.
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_MOD = 3'd4;
    localparam logic [2:0] OP_AND = 3'd5;
    localparam logic [2:0] OP_OR  = 3'd6;
    localparam logic [2:0] OP_XOR = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

endpackage

// File: rtl/alu_op_sequencer.sv
// Four-state controller sequencing one register-to-register ALU op: IDLE -> READ -> EXEC -> WB.
// Optional macro DIV0_CHECK_EN turns div/mod by zero into a faulted op (no write, done_err=1).
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int OP_W     = 3,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic [ADDR_W-1:0] in_rd,
    output logic [ADDR_W-1:0] rf_ra1,
    output logic [ADDR_W-1:0] rf_ra2,
    input  logic [DATA_W-1:0] rf_rd1,
    input  logic [DATA_W-1:0] rf_rd2,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wa,
    output logic [DATA_W-1:0] rf_wd,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_s,
    input  logic [DATA_W-1:0] alu_c,
    output logic              done,
    output logic              done_err,
    output logic [15:0]       op_count
);

    state_t            state;
    logic [OP_W-1:0]   op_l;
    logic [ADDR_W-1:0] rd_l;
    logic              wr_sup;

    assign wr_sup = (ZERO_REG != 0) && (rd_l == '0);

`ifdef DIV0_CHECK_EN
    logic fault;
    assign fault = ((op_l == OP_W'(OP_DIV)) || (op_l == OP_W'(OP_MOD))) && (alu_b == '0);
`else
    // The external ALU result is undefined for a zero divisor, so pin it to a known value.
    function automatic logic [DATA_W-1:0] div0_fix(input logic [OP_W-1:0]   op,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b,
                                                   input logic [DATA_W-1:0] c);
        if (b == '0 && op == OP_W'(OP_DIV))
            return '1;
        else if (b == '0 && op == OP_W'(OP_MOD))
            return a;
        else
            return c;
    endfunction
    assign done_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            op_l     <= '0;
            rd_l     <= '0;
            rf_ra1   <= '0;
            rf_ra2   <= '0;
            rf_we    <= 1'b0;
            rf_wa    <= '0;
            rf_wd    <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_s    <= '0;
            done     <= 1'b0;
            op_count <= '0;
`ifdef DIV0_CHECK_EN
            done_err <= 1'b0;
`endif
        end else begin
            rf_we <= 1'b0;
            done  <= 1'b0;
`ifdef DIV0_CHECK_EN
            done_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_l     <= in_op;
                        rd_l     <= in_rd;
                        rf_ra1   <= in_rs1;
                        rf_ra2   <= in_rs2;
                        in_ready <= 1'b0;
                        state    <= READ;
                    end
                end
                // READ: register-file data is valid this cycle; latch it as ALU operands
                READ: begin
                    alu_a <= rf_rd1;
                    alu_b <= rf_rd2;
                    alu_s <= op_l;
                    state <= EXEC;
                end
                // EXEC: ALU result is valid this cycle; stage the writeback
                EXEC: begin
                    alu_s    <= '0;
                    rf_wa    <= rd_l;
                    done     <= 1'b1;
                    op_count <= op_count + 16'd1;
`ifdef DIV0_CHECK_EN
                    rf_we    <= !(wr_sup || fault);
                    rf_wd    <= alu_c;
                    done_err <= fault;
`else
                    rf_we    <= !wr_sup;
                    rf_wd    <= div0_fix(op_l, alu_a, alu_b, alu_c);
`endif
                    state    <= WB;
                end
                WB: begin
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with behavioural register file and ALU models.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [4:0]  rf_ra1, rf_ra2, rf_wa;
    logic [31:0] rf_rd1, rf_rd2, rf_wd;
    logic        rf_we;
    logic [31:0] alu_a, alu_b, alu_c;
    logic [2:0]  alu_s;
    logic        done, done_err;
    logic [15:0] op_count;

    logic [31:0] rf [32];
    logic        load;
    int          cyc = 0;
    int          checks = 0;
    int          fails = 0;
    logic [15:0] exp_cnt = 16'd0;
    int          last_acc = -100;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        err;
        logic [15:0] cnt;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    alu_op_sequencer #(.DATA_W(32), .ADDR_W(5), .OP_W(3), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_c(alu_c),
        .done(done), .done_err(done_err), .op_count(op_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
            rf[1] <= 32'd7;
            rf[2] <= 32'd5;
            rf[4] <= 32'd0;
            rf[5] <= 32'h0001_0000;
            rf[6] <= 32'hF0F0_00FF;
        end else if (rf_we) begin
            rf[rf_wa] <= rf_wd;
        end
    end
    assign rf_rd1 = rf[rf_ra1];
    assign rf_rd2 = rf[rf_ra2];

    // External ALU; zero-divisor results are deliberately junk
    always_comb begin
        alu_c = 32'd0;
        case (alu_s)
            3'd0: alu_c = alu_a + alu_b;
            3'd1: alu_c = alu_a - alu_b;
            3'd2: alu_c = alu_a * alu_b;
            3'd3: alu_c = (alu_b == 0) ? 32'hDEAD_BEEF : alu_a / alu_b;
            3'd4: alu_c = (alu_b == 0) ? 32'hBAD0_0BAD : alu_a % alu_b;
            3'd5: alu_c = alu_a & alu_b;
            3'd6: alu_c = alu_a | alu_b;
            default: alu_c = alu_a ^ alu_b;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_done: got done=1 expected no pending op");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("wb_we", {31'd0, rf_we}, {31'd0, e.we});
                    if (e.we) begin
                        chk("wb_wa", {27'd0, rf_wa}, {27'd0, e.wa});
                        chk("wb_wd", rf_wd, e.wd);
                    end
                    chk("done_err", {31'd0, done_err}, {31'd0, e.err});
                    chk("op_count", {16'd0, op_count}, {16'd0, e.cnt});
                    chk("wb_cycle", 32'(cyc), 32'(e.cyc));
                end
            end else if (rf_we === 1'b1) begin
                checks++;
                fails++;
                $display("FAIL stray_we: got rf_we=1 expected 0 without done");
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic we, input logic [31:0] wd,
                         input logic err, input bit push, input bit b2b);
        int n = 0;
        exp_t e;
        in_valid = 1'b1;
        in_op    = op;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_rd    = rd;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            fails++;
            $display("FAIL accept_timeout: got in_ready=0 for 20 cycles expected 1");
        end else begin
            @(posedge clk);
            #1;
            if (b2b) chk("accept_interval", 32'(cyc - last_acc), 32'd4);
            last_acc = cyc;
            if (push) begin
                exp_cnt = exp_cnt + 16'd1;
                e.we  = we;
                e.wa  = rd;
                e.wd  = wd;
                e.err = err;
                e.cnt = exp_cnt;
                e.cyc = cyc + 2;
                sb.push_back(e);
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending ops expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        load = 1'b1;
        in_valid = 1'b0;
        in_op = 3'd0;
        in_rs1 = 5'd0;
        in_rs2 = 5'd0;
        in_rd = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        load = 1'b0;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_op_count", {16'd0, op_count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Four back-to-back requests with in_valid held high
        issue(3'd0, 5'd1, 5'd2, 5'd3, 1'b1, 32'd12, 1'b0, 1'b1, 1'b0);
        issue(3'd1, 5'd1, 5'd2, 5'd7, 1'b1, 32'd2,  1'b0, 1'b1, 1'b1);
        issue(3'd2, 5'd5, 5'd5, 5'd8, 1'b1, 32'd0,  1'b0, 1'b1, 1'b1);
        issue(3'd7, 5'd1, 5'd2, 5'd9, 1'b1, 32'd2,  1'b0, 1'b1, 1'b1);
        drain();
        chk("r3_readback", rf[3], 32'd12);
        chk("count_after_4", {16'd0, op_count}, 32'd4);

        issue(3'd0, 5'd3, 5'd1, 5'd11, 1'b1, 32'd19, 1'b0, 1'b1, 1'b0);
        issue(3'd5, 5'd6, 5'd1, 5'd10, 1'b1, 32'd7,  1'b0, 1'b1, 1'b1);
        issue(3'd6, 5'd1, 5'd2, 5'd17, 1'b1, 32'd7,  1'b0, 1'b1, 1'b1);
        issue(3'd0, 5'd1, 5'd2, 5'd0,  1'b0, 32'd12, 1'b0, 1'b1, 1'b1);
        drain();
        chk("r0_unchanged", rf[0], 32'd0);

`ifdef DIV0_CHECK_EN
        issue(3'd3, 5'd1, 5'd4, 5'd12, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        issue(3'd4, 5'd1, 5'd4, 5'd13, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1);
        drain();
        chk("r12_no_write", rf[12], 32'd0);
        chk("r13_no_write", rf[13], 32'd0);
`else
        issue(3'd3, 5'd1, 5'd4, 5'd12, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
        issue(3'd4, 5'd1, 5'd4, 5'd13, 1'b1, 32'd7,         1'b0, 1'b1, 1'b1);
        drain();
`endif
        issue(3'd3, 5'd1, 5'd2, 5'd14, 1'b1, 32'd1,  1'b0, 1'b1, 1'b0);
        issue(3'd4, 5'd1, 5'd2, 5'd15, 1'b1, 32'd2,  1'b0, 1'b1, 1'b1);
        issue(3'd0, 5'd1, 5'd1, 5'd1,  1'b1, 32'd14, 1'b0, 1'b1, 1'b1);
        drain();
        chk("r1_self_update", rf[1], 32'd14);

        // Abort an op while it sits in EXEC
        issue(3'd1, 5'd1, 5'd2, 5'd2, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_rf_we", {31'd0, rf_we}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_op_count", {16'd0, op_count}, 32'd0);
        exp_cnt = 16'd0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("r2_untouched", rf[2], 32'd5);

        issue(3'd0, 5'd2, 5'd2, 5'd16, 1'b1, 32'd10, 1'b0, 1'b1, 1'b0);
        drain();
        chk("r16_after_abort", rf[16], 32'd10);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
